// File: rtl/pattern_gen_pkg.sv
// Shared definitions for the pattern data generator and its future checker.
package pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_INC   = 2'd0,
        MODE_DEC   = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_WALK1 = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // x^32 + x^22 + x^2 + x + 1, Galois right-shift form
    localparam logic [31:0] DEFAULT_LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/pattern_data_generator_if.sv
// Valid/ready stream carrying pattern beats from the generator to the RAM write path.
interface pattern_data_generator_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/pattern_next_value.sv
// Combinational successor function for every pattern mode.
module pattern_next_value
    import pattern_gen_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(DEFAULT_LFSR_POLY)
) (
    input  mode_e             mode,
    input  logic [DATA_W-1:0] cur_value,
    output logic [DATA_W-1:0] next_value
);

    always_comb begin
        next_value = cur_value;
        unique case (mode)
            MODE_INC:   next_value = cur_value + DATA_W'(1);
            MODE_DEC:   next_value = cur_value - DATA_W'(1);
            MODE_LFSR:  next_value = cur_value[0] ? ((cur_value >> 1) ^ LFSR_POLY)
                                                  : (cur_value >> 1);
            MODE_WALK1: next_value = {cur_value[DATA_W-2:0], cur_value[DATA_W-1]};
            default:    next_value = cur_value;
        endcase
    end

endmodule

// File: rtl/pattern_data_generator.sv
// Burst test-data generator: BURST_LEN beats of INC/DEC/LFSR/WALK1 data per start,
// with the pattern register carried over from one burst to the next.
module pattern_data_generator
    import pattern_gen_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       BURST_LEN = 64,
    parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(DEFAULT_LFSR_POLY),
    localparam int unsigned      CNT_W     = $clog2(BURST_LEN)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic [1:0]                 i_mode,
    input  logic                       i_seed_load,
    input  logic [DATA_W-1:0]          i_seed,
    pattern_data_generator_if.master   stream,
    output logic [CNT_W-1:0]           o_count,
    output logic                       o_busy,
    output logic                       o_done
);

    state_e            state_q;
    mode_e             mode_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  count_q;
    logic              done_q;

    logic [DATA_W-1:0] next_val;
    logic [DATA_W-1:0] seed_val;
    logic [DATA_W-1:0] start_val;
    logic              running;
    logic              xfer;
    logic              last_beat;

    pattern_next_value #(
        .DATA_W    (DATA_W),
        .LFSR_POLY (LFSR_POLY)
    ) u_next (
        .mode       (mode_q),
        .cur_value  (data_q),
        .next_value (next_val)
    );

    assign running   = (state_q == ST_RUN);
    assign xfer      = running && stream.ready;
    assign last_beat = running && (count_q == CNT_W'(BURST_LEN - 1));

    // Seed is applied before the zero-lockup fix when both happen on the start edge.
    always_comb begin
        seed_val  = i_seed_load ? i_seed : data_q;
        start_val = seed_val;
        if ((mode_e'(i_mode) inside {MODE_LFSR, MODE_WALK1}) && (seed_val == '0)) begin
            start_val = DATA_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_INC;
            data_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q <= ST_RUN;
                        mode_q  <= mode_e'(i_mode);
                        count_q <= '0;
                        data_q  <= start_val;
                    end else if (i_seed_load) begin
                        data_q <= i_seed;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        data_q  <= next_val;
                        count_q <= last_beat ? '0 : count_q + CNT_W'(1);
                    end
                    // Abort wins over completion, so an aborted last beat never pulses done.
                    if (i_abort) begin
                        state_q <= ST_IDLE;
                    end else if (xfer && last_beat) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stream.valid = running;
    assign stream.data  = data_q;
    assign stream.last  = last_beat;
    assign o_count      = count_q;
    assign o_busy       = running;
    assign o_done       = done_q;

endmodule

// File: tb/tb_pattern_data_generator.sv
// Self-checking bench for pattern_data_generator: table vectors, directed burst sequences
// and a randomized run, all checked against a transaction-level reference model.
module tb_pattern_data_generator;
    import pattern_gen_pkg::*;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BURST_LEN = 64;
    localparam int unsigned CNT_W     = 6;
    localparam logic [31:0] POLY      = 32'h8020_0003;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_start;
    logic              i_abort;
    logic [1:0]        i_mode;
    logic              i_seed_load;
    logic [31:0]       i_seed;
    logic              i_ready;
    logic [CNT_W-1:0]  o_count;
    logic              o_busy;
    logic              o_done;

    pattern_data_generator_if #(.DATA_W(DATA_W)) stream ();
    assign stream.ready = i_ready;

    pattern_data_generator #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .LFSR_POLY (POLY)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_mode      (i_mode),
        .i_seed_load (i_seed_load),
        .i_seed      (i_seed),
        .stream      (stream),
        .o_count     (o_count),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: burst-level view (running flag, beats consumed, pattern value).
    bit          m_run;
    logic [1:0]  m_mode;
    logic [31:0] m_pat;
    int          m_beats;
    bit          m_done;

    logic [31:0] xq[$];
    logic [31:0] last_data;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] seed;
        logic [31:0] b0;
        logic [31:0] b1;
        logic [31:0] b2;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [31:0] ref_next(logic [1:0] m, logic [31:0] v);
        case (m)
            2'd0:    return v + 32'd1;
            2'd1:    return v - 32'd1;
            2'd2:    return (v >> 1) ^ (v[0] ? POLY : 32'h0);
            default: return {v[30:0], v[31]};
        endcase
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic quiet();
        i_rst = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_seed_load = 1'b0; i_ready = 1'b1;
    endtask

    // One clock: advance the model from the applied inputs, then compare every output.
    task automatic cyc();
        logic [63:0] act;
        logic [63:0] exp;
        if (stream.valid === 1'b1 && i_ready) begin
            xq.push_back(stream.data);
            if (stream.last === 1'b1) last_data = stream.data;
        end
        if (i_rst) begin
            m_run = 0; m_mode = 2'd0; m_pat = '0; m_beats = 0; m_done = 0;
        end else if (!m_run) begin
            m_done = 0;
            if (i_seed_load) m_pat = i_seed;
            if (i_start) begin
                m_run = 1; m_mode = i_mode; m_beats = 0;
                if (i_mode >= 2'd2 && m_pat == 32'd0) m_pat = 32'd1;
            end
        end else begin
            m_done = 0;
            if (i_ready) begin
                m_pat = ref_next(m_mode, m_pat);
                m_beats++;
            end
            if (i_abort) m_run = 0;
            else if (m_beats == BURST_LEN) begin m_run = 0; m_done = 1; end
        end
        @(posedge i_clk);
        #1;
        act = 64'({stream.valid, stream.last, o_busy, o_done, o_count, stream.data});
        exp = 64'({m_run, (m_run && m_beats == BURST_LEN - 1), m_run, m_done,
                   CNT_W'(m_beats % BURST_LEN), m_pat});
        check("cycle_outputs", act, exp);
    endtask

    task automatic do_reset();
        quiet();
        i_rst = 1'b1;
        cyc();
        cyc();
        i_rst = 1'b0;
    endtask

    task automatic start_burst(logic [1:0] mode);
        xq.delete();
        i_mode  = mode;
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
    endtask

    initial begin
        int vcyc;
        i_mode = 2'd0; i_seed = '0; last_data = '0;
        vecs[0] = '{2'd0, 32'd5,          32'd5,          32'd6,          32'd7};
        vecs[1] = '{2'd1, 32'd5,          32'd5,          32'd4,          32'd3};
        vecs[2] = '{2'd2, 32'd0,          32'd1,          32'h8020_0003,  32'hC030_0002};
        vecs[3] = '{2'd3, 32'd0,          32'd1,          32'd2,          32'd4};
        vecs[4] = '{2'd3, 32'h8000_0000,  32'h8000_0000,  32'd1,          32'd2};
        vecs[5] = '{2'd1, 32'd0,          32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFE};
        vecs[6] = '{2'd2, 32'd2,          32'd2,          32'd1,          32'h8020_0003};
        vecs[7] = '{2'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          32'd1};

        // Reset state and two back-to-back INC bursts
        do_reset();
        check("reset_valid", 64'(stream.valid), 64'd0);
        check("reset_data", 64'(stream.data), 64'd0);
        check("reset_count", 64'(o_count), 64'd0);
        start_burst(2'd0);
        check("t1_valid_after_start", 64'(stream.valid), 64'd1);
        for (int i = 0; i < 64; i++) cyc();
        check("t1_done_pulse", 64'(o_done), 64'd1);
        for (int i = 0; i < 64; i++) check("t1_data", 64'(xq[i]), 64'(i));
        check("t1_last_data", 64'(last_data), 64'd63);
        cyc();
        check("t1_done_cleared", 64'(o_done), 64'd0);
        start_burst(2'd0);
        check("t1_second_data", 64'(stream.data), 64'd64);
        check("t1_second_count", 64'(o_count), 64'd0);
        for (int i = 0; i < 64; i++) cyc();
        check("t1_second_end", 64'(xq[63]), 64'd127);

        // Alternating backpressure
        do_reset();
        start_burst(2'd0);
        vcyc = 0;
        for (int i = 0; i < 140; i++) begin
            i_ready = i[0];
            if (stream.valid === 1'b1) vcyc++;
            cyc();
        end
        i_ready = 1'b1;
        check("t2_valid_cycles", 64'(vcyc), 64'd128);
        check("t2_xfer_count", 64'(xq.size()), 64'd64);
        for (int i = 0; i < 64; i++) check("t2_order", 64'(xq[i]), 64'(i));

        // Seed load coincident with start, DEC
        do_reset();
        i_seed = 32'd5; i_seed_load = 1'b1;
        start_burst(2'd1);
        i_seed_load = 1'b0;
        for (int i = 0; i < 64; i++) cyc();
        check("t3_first", 64'(xq[0]), 64'd5);
        check("t3_zero", 64'(xq[5]), 64'd0);
        check("t3_wrap", 64'(xq[6]), 64'hFFFF_FFFF);
        check("t3_last", 64'(last_data), 64'hFFFF_FFC6);

        // LFSR and WALK1 from reset (zero-lockup fix)
        do_reset();
        start_burst(2'd2);
        for (int i = 0; i < 3; i++) cyc();
        check("t4_lfsr0", 64'(xq[0]), 64'd1);
        check("t4_lfsr1", 64'(xq[1]), 64'h8020_0003);
        check("t4_lfsr2", 64'(xq[2]), 64'hC030_0002);
        do_reset();
        start_burst(2'd3);
        for (int i = 0; i < 64; i++) cyc();
        for (int k = 0; k < 64; k++) check("t4_walk1", 64'(xq[k]), 64'(32'd1 << (k % 32)));

        // Abort mid-burst and on the last beat
        do_reset();
        start_burst(2'd0);
        for (int i = 0; i < 10; i++) cyc();
        i_ready = 1'b0; i_abort = 1'b1;
        cyc();
        i_ready = 1'b1; i_abort = 1'b0;
        check("t5_abort_valid", 64'(stream.valid), 64'd0);
        check("t5_abort_done", 64'(o_done), 64'd0);
        cyc();
        check("t5_abort_done2", 64'(o_done), 64'd0);
        start_burst(2'd0);
        check("t5_resume_data", 64'(stream.data), 64'd10);
        check("t5_resume_count", 64'(o_count), 64'd0);
        for (int i = 0; i < 63; i++) cyc();
        check("t5_at_last", 64'(stream.last), 64'd1);
        i_abort = 1'b1;
        cyc();
        i_abort = 1'b0;
        check("t5_last_abort_done", 64'(o_done), 64'd0);
        check("t5_last_abort_valid", 64'(stream.valid), 64'd0);
        check("t5_last_abort_data", 64'(stream.data), 64'd74);
        cyc();
        check("t5_last_abort_done2", 64'(o_done), 64'd0);

        // Control inputs ignored during RUN, then reset mid-burst
        do_reset();
        start_burst(2'd0);
        for (int i = 0; i < 20; i++) begin
            if (i >= 5 && i <= 15) begin
                i_start = 1'b1; i_seed_load = 1'b1; i_seed = 32'hDEAD_BEEF;
                i_mode = 2'($urandom_range(1, 3));
            end else begin
                i_start = 1'b0; i_seed_load = 1'b0;
            end
            cyc();
        end
        i_start = 1'b0; i_seed_load = 1'b0;
        check("t6_count20", 64'(o_count), 64'd20);
        check("t6_data20", 64'(stream.data), 64'd20);
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        check("t6_rst_outputs",
              64'({stream.valid, stream.last, o_busy, o_done, o_count, stream.data}), 64'd0);

        // Table vectors: seeded starts, first three beats, then abort
        foreach (vecs[v]) begin
            quiet();
            i_seed = vecs[v].seed; i_seed_load = 1'b1;
            start_burst(vecs[v].mode);
            i_seed_load = 1'b0;
            for (int i = 0; i < 3; i++) cyc();
            i_ready = 1'b0; i_abort = 1'b1;
            cyc();
            quiet();
            check("vec_b0", 64'(xq[0]), 64'(vecs[v].b0));
            check("vec_b1", 64'(xq[1]), 64'(vecs[v].b1));
            check("vec_b2", 64'(xq[2]), 64'(vecs[v].b2));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            i_rst       = ($urandom_range(0, 499) == 0);
            i_start     = ($urandom_range(0, 7) == 0);
            i_abort     = ($urandom_range(0, 39) == 0);
            i_seed_load = ($urandom_range(0, 5) == 0);
            i_seed      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            i_mode      = 2'($urandom_range(0, 3));
            i_ready     = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pattern_data_generator.md
Name: pattern_data_generator

Overview:
Parametrised successor of the team's incrementing data generator. Emits fixed-length bursts of test data over a valid/ready stream into the RAM write path. Supports four pattern modes, seed loading, downstream backpressure, abort, and done/last signalling. The pattern state persists across bursts, so each burst continues from where the previous one stopped.

Parameters:
DATA_W, 32, data width in bits (>= 2)
BURST_LEN, 64, beats per burst (>= 2)
LFSR_POLY, 32'h8020_0003, Galois right-shift feedback mask (DATA_W bits); default is x^32+x^22+x^2+x+1
CNT_W, $clog2(BURST_LEN), beat-index width (derived; do not override)

Ports:
i_clk  in  1  system clock; all logic on posedge
i_rst  in  1  synchronous, active-high reset
i_start  in  1  burst start pulse; honoured in IDLE only
i_abort  in  1  terminate the current burst; honoured in RUN only
i_mode  in  2  pattern select, latched at start: 0 INC, 1 DEC, 2 LFSR, 3 WALK1
i_seed_load  in  1  load i_seed into the pattern register; honoured in IDLE only
i_seed  in  DATA_W  seed value
i_ready  in  1  downstream ready
o_valid  out  1  o_data valid
o_data  out  DATA_W  current pattern value
o_last  out  1  high with o_valid on the final beat of a burst
o_count  out  CNT_W  index of the beat currently presented (0..BURST_LEN-1)
o_busy  out  1  high in RUN state
o_done  out  1  one-cycle pulse after a burst completes normally

Behaviour:
- Reset values: o_valid 0, o_data 0, o_last 0, o_count 0, o_busy 0, o_done 0. State goes to IDLE; latched mode goes to INC.
- States are IDLE and RUN. o_busy = o_valid = (state == RUN).
- A transfer occurs when o_valid && i_ready. On a transfer, o_data advances to the next pattern value and o_count increments. Without a transfer, both hold.
- Next value by mode:
  - INC: +1 mod 2^DATA_W.
  - DEC: -1 mod 2^DATA_W.
  - LFSR: lsb ? (d>>1)^LFSR_POLY : d>>1.
  - WALK1: rotate left by 1.
- IDLE -> RUN when i_start is high, with latency 1: start at cycle N gives o_valid at N+1.
  - On the transition: latch i_mode and clear o_count.
  - If the latched mode is LFSR or WALK1 and the pattern register is 0, load 1 (zero-lockup fix).
- i_seed_load in IDLE loads i_seed on the next edge. If it coincides with i_start, the seed is loaded first, then the zero-fix is applied.
- i_seed_load, i_start and i_mode are ignored during RUN.
- o_last = o_valid && (o_count == BURST_LEN-1).
- Transfer with o_last high:
  - RUN -> IDLE on the next edge.
  - o_done = 1 for exactly that following cycle.
  - The pattern register has already advanced, so the next burst starts at the following value.
- i_abort in RUN:
  - RUN -> IDLE on the next edge; no o_done.
  - A transfer in the same cycle still counts, and the data advances.
  - Abort has priority over completion: abort on the last-beat transfer gives no o_done.
  - The pattern register holds the first unconsumed value.
- o_count resets at each start. There is no count carry between bursts.
- i_rst mid-burst: all outputs return to reset values on the next edge, and the pattern register returns to 0.

Decomposition:
- Package pattern_gen_pkg holds:
  - mode constants MODE_INC=2'd0, MODE_DEC=2'd1, MODE_LFSR=2'd2, MODE_WALK1=2'd3;
  - state encoding ST_IDLE / ST_RUN;
  - default LFSR_POLY.
- One combinational sub-module, pattern_next_value (inputs: mode, current value; parameters: DATA_W, LFSR_POLY; output: next value). Reused by the future checker.
- FSM, counters and handshake live in the top module.

Test Plan:
1. Reset; INC; i_ready=1 throughout; start.
   -> o_valid for 64 cycles, data 0..63, o_last on 63, o_done the cycle after.
   -> Second start gives 64..127, o_count restarting at 0.
2. INC with i_ready alternating 1/0.
   -> Data advances only on ready; burst spans 128 cycles; values 0..63 in order, no duplicates or gaps.
3. seed_load 5 plus start in the same cycle, DEC.
   -> Beats 5,4,...,0,FFFFFFFF,...; last beat 0xFFFFFFC6 with o_last high.
4. From reset, LFSR start.
   -> Beats 1, 0x80200003, 0xC0300002, ...
   -> WALK1 start from reset: beat k = 1<<(k mod 32).
5. INC abort after 10 transfers.
   -> o_valid low next cycle, no o_done.
   -> Next start begins at data 10, o_count 0.
   -> Abort coincident with the last beat: no o_done.
6. i_rst at beat 20.
   -> All outputs 0 the next cycle.
   -> i_start, i_seed_load and i_mode changes during RUN have no effect on data or count.
